// File: rtl/fsm_input_cond.sv
// Two-channel sync + debounce front end for the coin/selection FSM.
// Yields clean levels, edge pulses and a saturating glitch count.
module fsm_input_cond #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 3,
  parameter int GW        = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          raw_a,
  input  logic          raw_i,
  output logic          a9,
  output logic          i9,
  output logic          a_rise,
  output logic          i_rise,
  output logic          a_fall,
  output logic          i_fall,
  output logic          pair_chg,
  output logic [GW-1:0] glitch_cnt
);

  localparam logic [CW-1:0] DB_M1 = CW'(DB_CYCLES - 1);
  localparam logic [GW:0] G_MAX = {1'b0, {GW{1'b1}}};

  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    stb;
  logic [1:0]    prv;
  logic [CW-1:0] cnt [2];
  logic [1:0]    glt;
  logic [GW:0]   gsum;
  logic [GW-1:0] gnext;
  logic [1:0]    chg;

  always_comb begin
    glt = '0;
    for (int c = 0; c < 2; c++) begin
      glt[c] = (s2[c] == stb[c]) && (cnt[c] != '0);
    end
  end

  // +2 on a joint glitch still clamps at the all-ones value
  always_comb begin
    gsum = {1'b0, glitch_cnt}
         + (GW+1)'(glt[0])
         + (GW+1)'(glt[1]);
    gnext = (gsum > G_MAX) ? G_MAX[GW-1:0]
                           : gsum[GW-1:0];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1         <= '0;
      s2         <= '0;
      stb        <= '0;
      prv        <= '0;
      cnt[0]     <= '0;
      cnt[1]     <= '0;
      glitch_cnt <= '0;
    end else begin
      s1         <= {raw_i, raw_a};
      s2         <= s1;
      prv        <= stb;
      glitch_cnt <= gnext;
      for (int c = 0; c < 2; c++) begin
        if (s2[c] == stb[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == DB_M1) begin
          stb[c] <= s2[c];
          cnt[c] <= '0;
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end

  assign chg      = stb ^ prv;
  assign a9       = stb[0];
  assign i9       = stb[1];
  assign a_rise   = stb[0] & ~prv[0];
  assign i_rise   = stb[1] & ~prv[1];
  assign a_fall   = ~stb[0] & prv[0];
  assign i_fall   = ~stb[1] & prv[1];
  assign pair_chg = chg[0] & chg[1];

endmodule

// File: tb/tb_fsm_input_cond.sv
// Bench for fsm_input_cond: directed and random raw stimulus
// against a sample-history reference model; second copy has GW=2.
module tb_fsm_input_cond;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       raw_a = 1'b0;
  logic       raw_i = 1'b0;
  logic       a9, i9, a_rise, i_rise;
  logic       a_fall, i_fall, pair_chg;
  logic [7:0] glitch_cnt;
  logic       s_a9, s_i9, s_ar, s_ir;
  logic       s_af, s_if, s_pc;
  logic [1:0] s_gc;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fsm_input_cond #(.DB_CYCLES(DB), .CW(3), .GW(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .raw_a(raw_a), .raw_i(raw_i),
    .a9(a9), .i9(i9),
    .a_rise(a_rise), .i_rise(i_rise),
    .a_fall(a_fall), .i_fall(i_fall),
    .pair_chg(pair_chg), .glitch_cnt(glitch_cnt)
  );

  fsm_input_cond #(.DB_CYCLES(DB), .CW(3), .GW(2)) u_sat (
    .clk(clk), .rst_b(rst_b),
    .raw_a(raw_a), .raw_i(raw_i),
    .a9(s_a9), .i9(s_i9),
    .a_rise(s_ar), .i_rise(s_ir),
    .a_fall(s_af), .i_fall(s_if),
    .pair_chg(s_pc), .glitch_cnt(s_gc)
  );

  // model: raw history since reset, last flip edge per channel
  logic [1:0] hist[$];
  int         fe[2];
  logic [1:0] mstb, mold;
  int         mg, mgs;

  function automatic logic smp(int n, int c);
    logic [1:0] h;
    if (n <= 2) return 1'b0;
    h = hist[n-3];
    return h[c];
  endfunction

  task automatic model_reset();
    hist.delete();
    fe[0] = 0;
    fe[1] = 0;
    mstb = '0;
    mold = '0;
    mg = 0;
    mgs = 0;
  endtask

  task automatic model_edge(input logic ra, input logic ri);
    int n;
    int gl;
    bit ok;
    logic x;
    hist.push_back({ri, ra});
    n = hist.size();
    mold = mstb;
    gl = 0;
    for (int c = 0; c < 2; c++) begin
      x = smp(n, c);
      if (x != mold[c]) begin
        ok = (n - fe[c]) >= DB;
        for (int k = 0; k < DB; k++)
          if (ok && smp(n - k, c) == mold[c]) ok = 0;
        if (ok) begin
          mstb[c] = x;
          fe[c] = n;
        end
      end else if (n - 1 > fe[c] &&
                   smp(n - 1, c) != mold[c]) begin
        gl++;
      end
    end
    mg  = (mg + gl > 255) ? 255 : mg + gl;
    mgs = (mgs + gl > 3) ? 3 : mgs + gl;
  endtask

  task automatic check();
    logic [6:0] obs, exp, sobs;
    obs = {a9, i9, a_rise, i_rise,
           a_fall, i_fall, pair_chg};
    sobs = {s_a9, s_i9, s_ar, s_ir,
            s_af, s_if, s_pc};
    exp = {mstb[0], mstb[1],
           mstb[0] & ~mold[0], mstb[1] & ~mold[1],
           ~mstb[0] & mold[0], ~mstb[1] & mold[1],
           (mstb[0] ^ mold[0]) & (mstb[1] ^ mold[1])};
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL levels obs=%b exp=%b t=%0t", obs, exp, $time);
    end
    nvec++;
    assert (glitch_cnt === 8'(mg)) else begin
      nerr++;
      $error("FAIL glitch obs=%0d exp=%0d t=%0t",
             glitch_cnt, mg, $time);
    end
    nvec++;
    assert ({sobs, s_gc} === {exp, 2'(mgs)}) else begin
      nerr++;
      $error("FAIL sat obs=%b/%0d exp=%b/%0d t=%0t",
             sobs, s_gc, exp, mgs, $time);
    end
  endtask

  task automatic step(input logic ra, input logic ri);
    raw_a = ra;
    raw_i = ri;
    @(posedge clk);
    model_edge(ra, ri);
    #1;
    check();
  endtask

  task automatic hold(input logic ra, input logic ri, input int k);
    for (int j = 0; j < k; j++) step(ra, ri);
  endtask

  task automatic do_reset(input logic ra, input logic ri);
    logic [18:0] z;
    raw_a = ra;
    raw_i = ri;
    rst_b = 1'b0;
    #1;
    model_reset();
    z = {a9, i9, a_rise, i_rise, a_fall, i_fall,
         pair_chg, glitch_cnt, s_gc, s_a9, s_i9};
    nvec++;
    assert (z === '0) else begin
      nerr++;
      $error("FAIL in_reset obs=%h exp=0", z);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    model_reset();
    // reset with both raw inputs high, release at t=100
    raw_a = 1'b1;
    raw_i = 1'b1;
    #1;
    nvec++;
    assert ({a9, i9, glitch_cnt} === 10'd0) else begin
      nerr++;
      $error("FAIL por obs=%b exp=0", {a9, i9, glitch_cnt});
    end
    #99;
    rst_b = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1'b1, 1'b1);
      nvec++;
      assert ({a9, i9, pair_chg} ===
              ((e < 6) ? 3'b000 : (e == 6) ? 3'b111 : 3'b110))
      else begin
        nerr++;
        $error("FAIL rel_edge%0d obs=%b", e, {a9, i9, pair_chg});
      end
    end

    // clean transitions on raw_a only
    do_reset(1'b0, 1'b0);
    hold(0, 0, 3);
    hold(1, 0, 10);
    hold(0, 0, 10);

    // bounce rejection on raw_i: 2 high, 3 low, 1 high
    hold(0, 1, 2);
    hold(0, 0, 3);
    hold(0, 1, 1);
    hold(0, 0, 6);
    nvec++;
    assert (glitch_cnt === 8'd2 && i9 === 1'b0) else begin
      nerr++;
      $error("FAIL bounce obs=%0d/%b exp=2/0", glitch_cnt, i9);
    end

    // simultaneous glitch: +2 on one edge
    hold(1, 1, 2);
    hold(0, 0, 6);

    // saturation: 5 single glitches, then joint at count 2
    for (int g = 0; g < 5; g++) begin
      hold(1, 0, 2);
      hold(0, 0, 4);
    end
    nvec++;
    assert (s_gc === 2'd3) else begin
      nerr++;
      $error("FAIL sat_hold obs=%0d exp=3", s_gc);
    end
    do_reset(1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      hold(0, 1, 3);
      hold(0, 0, 4);
    end
    hold(1, 1, 2);
    hold(0, 0, 5);
    nvec++;
    assert (s_gc === 2'd3 && glitch_cnt === 8'd4) else begin
      nerr++;
      $error("FAIL sat_pair obs=%0d/%0d exp=3/4",
             s_gc, glitch_cnt);
    end

    // reset mid-debounce, raw_a still high afterwards
    hold(1, 0, 4);
    do_reset(1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      step(1'b1, 1'b0);
      nvec++;
      assert (a9 === (e == 6)) else begin
        nerr++;
        $error("FAIL mid_rst_edge%0d obs=%b exp=%b",
               e, a9, (e == 6));
      end
    end

    // random raw activity with mixed hold lengths
    for (int r = 0; r < 1500; r++) begin
      logic ra, ri;
      ra = raw_a;
      ri = raw_i;
      if ($urandom_range(0, 4) == 0) ra = ~ra;
      if ($urandom_range(0, 4) == 0) ri = ~ri;
      if ($urandom_range(0, 9) == 0)
        hold(ra, ri, $urandom_range(4, 9));
      else
        step(ra, ri);
      if (r == 700) do_reset(raw_a, raw_i);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fsm_input_cond.md
Name: fsm_input_cond

Overview:
Input conditioning stage that sits directly upstream of the coin/selection control FSM. It takes two raw, asynchronous, bouncy inputs (raw_a, raw_i) and synchronizes and debounces them. It drives the clean levels a9/i9 that the FSM samples every clock, plus one-cycle edge pulses and a saturating glitch counter for diagnostics. The two channels are identical and independent, except for the shared glitch counter and the pair-change strobe.

Parameters:
DB_CYCLES, 4, consecutive cycles the synchronized input must differ from the stable level before the stable level flips; legal range 1..2^CW-1
CW, 3, width of each per-channel debounce counter
GW, 8, width of the shared glitch counter

Ports:
clk  input  1  system clock, rising edge
rst_b  input  1  asynchronous active-low reset
raw_a  input  1  raw asynchronous "a" input
raw_i  input  1  raw asynchronous "i" input
a9  output  1  debounced stable level of raw_a
i9  output  1  debounced stable level of raw_i
a_rise  output  1  one-cycle pulse on the first cycle a9 is 1 after being 0
i_rise  output  1  one-cycle pulse on the first cycle i9 is 1 after being 0
a_fall  output  1  one-cycle pulse on the first cycle a9 is 0 after being 1
i_fall  output  1  one-cycle pulse on the first cycle i9 is 0 after being 1
pair_chg  output  1  one-cycle pulse when a9 and i9 both change on the same edge
glitch_cnt  output  GW  count of rejected bounces, both channels combined, saturating

Behaviour:
- Reset: clk and rst_b as already decided; reset is asynchronous, active-low, applied immediately.
  - Cleared by reset: sync flops s1/s2, stable levels (a9=i9=0), debounce counters, previous-level registers, glitch_cnt=0.
  - All pulses are 0 during reset.
- Synchronizer: 2-flop per channel; s1<=raw, s2<=s1. Only s2 feeds the debounce logic.
- Debounce, per channel, evaluated every rising edge:
  - s2==stable: cnt<=0. If cnt!=0 before this edge, the edge is a glitch (see glitch counter).
  - s2!=stable and cnt==DB_CYCLES-1: stable<=s2, cnt<=0.
  - s2!=stable otherwise: cnt<=cnt+1.
- Latency: a raw change held steady flips the stable level on the (DB_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1. Default: 6 edges.
- Filtering: any raw pulse shorter than DB_CYCLES cycles after synchronization never reaches a9/i9.
- Edge pulses:
  - Each channel keeps a previous-level register prev<=stable.
  - rise = stable & ~prev; fall = ~stable & prev.
  - Each pulse is high exactly one cycle, coincident with the first cycle of the new level.
  - rise and fall of the same channel are never high together.
- pair_chg = (a9^a_prev) & (i9^i_prev), regardless of direction.
- Glitch counter:
  - Per channel, a glitch is an edge where cnt!=0 and s2==stable.
  - Increment by 1 for a single-channel glitch, by 2 when both channels glitch on the same edge.
  - Saturates at 2^GW-1 and never wraps; the +2 case also clamps to 2^GW-1.
- A stable flip (cnt==DB_CYCLES-1 path) is not a glitch.
- Reset mid-debounce discards the pending count. After release, a raw input still held high is re-debounced from 0 with full latency.
- DB_CYCLES=1: the stable level follows s2 with one extra edge of delay and glitch_cnt never increments.
- The block has no handshake: outputs are valid every cycle and the downstream FSM samples a9/i9 directly.

Test Plan:
- Reset behaviour: rst_b=0, raw_a=raw_i=1, release at t=100 -> a9=i9=0 until edge 6 after release, then a9=i9=1, a_rise=i_rise=1 and pair_chg=1 for one cycle, glitch_cnt=0.
- Clean transition: raw_a 0->1 held 10 cycles, DB=4 -> a9 rises on edge 6, a_rise high exactly one cycle. Then raw_a 1->0 -> a_fall one cycle 6 edges later; i9 unaffected.
- Bounce rejection: raw_i pulses high 2 cycles, low 3, high 1 -> i9 stays 0, glitch_cnt increments by 1 per rejected burst (2 total), no i_rise.
- Simultaneous glitch: raw_a and raw_i pulse high 2 cycles together -> glitch_cnt +2 on the same edge, no level change.
- Saturation: GW=2, inject 5 single-channel glitches -> glitch_cnt reaches 3 and holds 3. With glitch_cnt=2, a simultaneous glitch -> 3.
- Reset mid-operation: raw_a high, assert rst_b low after 4 edges (cnt=2), release -> a9 rises exactly 6 edges after release, not earlier.
